// File: rtl/conv_datapath_pkg.sv
// conv_datapath_pkg: shared widths and controller state encoding for the convolution datapath.
package conv_datapath_pkg;
  localparam int BYTE = 8;
  localparam int HALF_WORD = 16;
  localparam int ACC_W = 32;
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_e;
endpackage

// File: rtl/conv_datapath_sat_round.sv
// sat_round: rounding arithmetic right shift of the accumulator, clipped to a signed byte.
module sat_round #(
  parameter int OUT_SHIFT = 0,
  parameter int ACC_W = 32
) (
  input  logic signed [ACC_W-1:0] acc_i,
  output logic signed [7:0]       res_o,
  output logic                    clip_o
);
  // one extra bit so the rounding add cannot wrap
  localparam logic signed [ACC_W:0] RND = (ACC_W+1)'((1 << OUT_SHIFT) >> 1);
  logic signed [ACC_W:0] r;
  assign r = ((ACC_W+1)'(acc_i) + RND) >>> OUT_SHIFT;
  assign clip_o = (r > 127) || (r < -128);
  assign res_o = r > 127 ? 8'sh7f : r < -128 ? 8'sh80 : r[7:0];
endmodule

// File: rtl/conv_datapath.sv
// conv_datapath: bias-seeded MAC accumulator with rounding saturation and a one-cycle-latency write port.
module conv_datapath
  import conv_datapath_pkg::*;
#(
  parameter int BIAS_SHIFT = 0,
  parameter int OUT_SHIFT = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        en_read,
  input  logic                        en_mac,
  input  logic                        s_convout,
  input  logic                        en_sat,
  input  logic                        en_write,
  input  logic                        pad,
  input  logic signed [BYTE-1:0]      s_data,
  input  logic signed [BYTE-1:0]      w_data,
  input  logic signed [BYTE-1:0]      b_data,
  input  logic [HALF_WORD-1:0]        save_addr,
  output logic                        wr_en,
  output logic [HALF_WORD-1:0]        wr_addr,
  output logic signed [BYTE-1:0]      wr_data,
  output logic                        busy,
  output logic                        sat_flag,
  output logic                        err_flag
);
  state_e state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [BYTE-1:0] op_s_q, op_w_q, res_q, sat_res;
  logic [HALF_WORD-1:0] addr_q;
  logic signed [2*BYTE-1:0] prod;
  logic mac_seed, mac_add, do_sat, do_wr, err_set, clip;
  assign prod = (2*BYTE)'(op_s_q) * (2*BYTE)'(op_w_q);
  assign do_wr = en_write && state_q == HOLD;
  // a write in HOLD frees the accumulator, so a MAC in the same cycle starts a new window
  assign mac_seed = en_mac && (state_q == IDLE || do_wr);
  assign do_sat = en_sat && state_q == ACCUM;
  assign mac_add = en_mac && state_q == ACCUM && !en_sat;
  assign err_set = (en_mac && state_q == HOLD && !en_write) || (en_sat && state_q == IDLE)
                || (en_write && state_q != HOLD) || (do_sat && en_mac);
  assign acc_d = mac_seed ? (ACC_W'(b_data) <<< BIAS_SHIFT) + ACC_W'(prod)
               : mac_add ? acc_q + ACC_W'(prod) : acc_q;
  assign state_d = mac_seed ? ACCUM : do_sat ? HOLD : do_wr ? IDLE : state_q;
  assign busy = state_q != IDLE;
  sat_round #(.OUT_SHIFT(OUT_SHIFT), .ACC_W(ACC_W)) u_sat (
    .acc_i (acc_q),
    .res_o (sat_res),
    .clip_o(clip)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      op_s_q   <= '0;
      op_w_q   <= '0;
      res_q    <= '0;
      addr_q   <= '0;
      wr_en    <= 1'b0;
      wr_data  <= '0;
      wr_addr  <= '0;
      sat_flag <= 1'b0;
      err_flag <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      wr_en    <= do_wr;
      err_flag <= err_flag | err_set;
      if (en_read) begin
        op_s_q <= pad ? '0 : s_data;
        op_w_q <= w_data;
      end
      if (s_convout) addr_q <= save_addr;
      if (do_sat) begin
        res_q    <= sat_res;
        sat_flag <= sat_flag | clip;
      end
      if (do_wr) begin
        wr_data <= res_q;
        wr_addr <= addr_q;
      end
    end
  end
endmodule
